// File: rtl/sd_fifo_arb_pkg.sv
// Shared types and the round-robin pick helper for the sd_fifo_arb arbiter family.
// rr_next works on up to 16 requesters; callers pass their real requester count in n.
package sd_fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int RR_MAX = 16;

    // Lowest requester above ptr wins; if none, wrap and take the lowest requester overall.
    function automatic logic [RR_MAX-1:0] rr_next(input logic [RR_MAX-1:0] req,
                                                  input logic [3:0]        ptr,
                                                  input int                n);
        logic [RR_MAX-1:0] valid;
        logic [RR_MAX-1:0] mask;
        logic [RR_MAX-1:0] src;
        logic [RR_MAX-1:0] pick;
        valid = '0;
        mask  = '0;
        pick  = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            valid[k] = (k < n);
            mask[k]  = (k > int'(ptr)) && (k < n);
        end
        src = ((req & mask) != '0) ? (req & mask) : (req & valid);
        for (int k = 0; k < RR_MAX; k++) begin
            if (src[k] && (pick == '0)) begin
                pick[k] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sd_fifo_arb_if.sv
// Requester-side and FIFO-side handshake bundle of sd_fifo_arb.
// master is the arbiter's view; slave is the view of whatever surrounds it.
interface sd_fifo_arb_if #(
    parameter int inputs = 4,
    parameter int width  = 8,
    parameter int usz    = 3
);
    logic [inputs-1:0]       c_srdy;
    logic [inputs-1:0]       c_eop;
    logic [inputs*width-1:0] c_data;
    logic [inputs-1:0]       c_drdy;
    logic                    p_srdy;
    logic                    p_eop;
    logic [width-1:0]        p_data;
    logic                    p_drdy;
    logic [usz-1:0]          fifo_usage;
    logic [inputs-1:0]       p_grant;

    modport master (
        input  c_srdy, c_eop, c_data, p_drdy, fifo_usage,
        output c_drdy, p_srdy, p_eop, p_data, p_grant
    );

    modport slave (
        output c_srdy, c_eop, c_data, p_drdy, fifo_usage,
        input  c_drdy, p_srdy, p_eop, p_data, p_grant
    );
endinterface

// File: rtl/sd_rr_pick.sv
// Combinational masked round-robin pick: one-hot winner and its index, searching from ptr+1.
module sd_rr_pick
    import sd_fifo_arb_pkg::*;
#(
    parameter int inputs = 4,
    parameter int pw     = 2
) (
    input  logic [inputs-1:0] req,
    input  logic [pw-1:0]     ptr,
    output logic [inputs-1:0] grant,
    output logic [pw-1:0]     idx
);

    logic [RR_MAX-1:0] pick;

    always_comb begin
        pick  = rr_next(RR_MAX'(req), 4'(ptr), inputs);
        grant = pick[inputs-1:0];
        idx   = '0;
        for (int k = 0; k < inputs; k++) begin
            if (pick[k]) begin
                idx = pw'(k);
            end
        end
    end

    generate
        if (inputs < RR_MAX) begin : g_pad
            logic unused_pick;
            assign unused_pick = ^pick[RR_MAX-1:inputs];
        end
    endgenerate

endmodule

// File: rtl/sd_fifo_arb.sv
// Round-robin arbiter feeding one sd_fifo_c write port, with optional packet lock
// and a high-water throttle on starting new packets.
//
//   state      | meaning
//   ARB_IDLE   | no packet open; rr pick among requesters unless throttled
//   ARB_LOCKED | packet from lock_idx in flight; grant held until its eop beat
module sd_fifo_arb
    import sd_fifo_arb_pkg::*;
#(
    parameter int inputs   = 4,
    parameter int width    = 8,
    parameter int usz      = 3,
    parameter int hiwat    = 4,
    parameter int lock_pkt = 1
) (
    input logic             clk,
    input logic             reset,
    sd_fifo_arb_if.master   bus
);

    localparam int pw = (inputs > 1) ? $clog2(inputs) : 1;

    arb_state_t        state, state_nxt;
    logic [pw-1:0]     ptr, ptr_nxt;
    logic [pw-1:0]     lock_idx, lock_nxt;
    logic [inputs-1:0] pick_oh;
    logic [pw-1:0]     pick_idx;
    logic [inputs-1:0] grant;
    logic [pw-1:0]     gidx;
    logic              throttle;
    logic              psrdy;
    logic              xfer;

    sd_rr_pick #(
        .inputs (inputs),
        .pw     (pw)
    ) u_pick (
        .req   (bus.c_srdy),
        .ptr   (ptr),
        .grant (pick_oh),
        .idx   (pick_idx)
    );

    assign throttle = int'(bus.fifo_usage) >= hiwat;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ARB_IDLE;
            ptr      <= pw'(inputs - 1);
            lock_idx <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            lock_idx <= lock_nxt;
        end
    end

    always_comb begin
        grant     = '0;
        gidx      = pick_idx;
        state_nxt = state;
        ptr_nxt   = ptr;
        lock_nxt  = lock_idx;
        // Grant is forced off while reset is low so nothing leaks into the FIFO.
        if (reset) begin
            if (state == ARB_LOCKED) begin
                gidx           = lock_idx;
                grant[lock_idx] = 1'b1;
            end else if (!throttle) begin
                grant = pick_oh;
            end
        end
        psrdy = |(grant & bus.c_srdy);
        xfer  = psrdy & bus.p_drdy;
        if (xfer) begin
            if (state == ARB_LOCKED) begin
                if (bus.c_eop[lock_idx]) begin
                    state_nxt = ARB_IDLE;
                    ptr_nxt   = lock_idx;
                end
            end else if ((lock_pkt != 0) && !bus.c_eop[gidx]) begin
                state_nxt = ARB_LOCKED;
                lock_nxt  = gidx;
            end else begin
                ptr_nxt = gidx;
            end
        end
    end

    assign bus.p_grant = grant;
    assign bus.p_srdy  = psrdy;
    assign bus.c_drdy  = grant & {inputs{bus.p_drdy}};
    assign bus.p_eop   = bus.c_eop[gidx];
    assign bus.p_data  = bus.c_data[gidx*width +: width];

endmodule

// File: tb/tb_sd_fifo_arb.sv
// Scoreboarded bench for sd_fifo_arb: directed scenarios followed by a long random run.
module tb_sd_fifo_arb;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int USZ   = 3;
    localparam int HIWAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sd_fifo_arb_if #(.inputs(N), .width(W), .usz(USZ)) bus ();

    sd_fifo_arb #(
        .inputs   (N),
        .width    (W),
        .usz      (USZ),
        .hiwat    (HIWAT),
        .lock_pkt (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         eop;
    } beat_t;

    typedef struct {
        logic [N-1:0] grant;
        logic         srdy;
        logic [N-1:0] drdy;
        logic         xfer;
        logic [W-1:0] data;
        logic         eop;
    } exp_t;

    beat_t src_q[N][$];
    exp_t  exp_q[$];

    int tests = 0;
    int fails = 0;
    bit mon_on = 1'b0;

    // Reference model: owner of an open packet (-1 if none) and last finished winner.
    int m_owner = -1;
    int m_last  = N - 1;

    logic [N-1:0]   gate = '0;
    logic           drdy_v = 1'b1;
    logic [USZ-1:0] usage_v = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int i, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = W'($urandom);
            b.eop  = (k == len - 1);
            src_q[i].push_back(b);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) src_q[i].delete();
    endtask

    task automatic drive_cycle();
        logic [N-1:0]   srdy;
        logic [N-1:0]   eop;
        logic [N*W-1:0] data;
        exp_t           e;
        int             cand;
        bit             found;
        srdy = '0;
        eop  = '0;
        data = '0;
        for (int i = 0; i < N; i++) begin
            if (gate[i] && src_q[i].size() > 0) begin
                srdy[i]         = 1'b1;
                eop[i]          = src_q[i][0].eop;
                data[i*W +: W]  = src_q[i][0].data;
            end else begin
                eop[i]          = 1'($urandom);
                data[i*W +: W]  = W'($urandom);
            end
        end
        bus.c_srdy     = srdy;
        bus.c_eop      = eop;
        bus.c_data     = data;
        bus.p_drdy     = drdy_v;
        bus.fifo_usage = usage_v;

        cand = -1;
        if (reset) begin
            if (m_owner >= 0) begin
                cand = m_owner;
            end else if (int'(usage_v) < HIWAT) begin
                found = 1'b0;
                for (int j = 1; j <= N; j++) begin
                    if (!found && srdy[(m_last + j) % N]) begin
                        cand  = (m_last + j) % N;
                        found = 1'b1;
                    end
                end
            end
        end
        e.grant = '0;
        e.srdy  = 1'b0;
        e.data  = '0;
        e.eop   = 1'b0;
        if (cand >= 0) begin
            e.grant[cand] = 1'b1;
            e.srdy        = srdy[cand];
        end
        e.drdy = drdy_v ? e.grant : '0;
        e.xfer = e.srdy && drdy_v;
        if (e.xfer) begin
            e.data = src_q[cand][0].data;
            e.eop  = src_q[cand][0].eop;
        end
        exp_q.push_back(e);

        if (!reset) begin
            m_owner = -1;
            m_last  = N - 1;
        end else if (e.xfer) begin
            void'(src_q[cand].pop_front());
            if (m_owner < 0) begin
                if (!e.eop) m_owner = cand;
                else        m_last  = cand;
            end else if (e.eop) begin
                m_owner = -1;
                m_last  = cand;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) drive_cycle();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_on) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: got no expectation for DUT output at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("p_grant", 32'(bus.p_grant), 32'(e.grant));
                chk("p_srdy",  32'(bus.p_srdy),  32'(e.srdy));
                chk("c_drdy",  32'(bus.c_drdy),  32'(e.drdy));
                if (e.xfer) begin
                    chk("p_data", 32'(bus.p_data), 32'(e.data));
                    chk("p_eop",  32'(bus.p_eop),  32'(e.eop));
                end
            end
        end
    end

    initial begin
        bus.c_srdy     = '0;
        bus.c_eop      = '0;
        bus.c_data     = '0;
        bus.p_drdy     = 1'b1;
        bus.fifo_usage = '0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        // Reset with everyone requesting, then single-beat rotation 0,1,2,3,0.
        for (int i = 0; i < N; i++) begin
            add_pkt(i, 1);
            add_pkt(i, 1);
        end
        gate  = '1;
        reset = 1'b0;
        run(3);
        reset = 1'b1;
        run(5);

        // Locked 3-beat packet from input 2 while 0 and 1 request.
        clear_src();
        add_pkt(2, 3);
        add_pkt(0, 1);
        add_pkt(1, 1);
        gate = 4'b0100;
        run(1);
        gate = 4'b0111;
        run(6);

        // Throttle in idle, then release.
        clear_src();
        for (int i = 0; i < N; i++) add_pkt(i, 1);
        gate    = '1;
        usage_v = 3'd4;
        run(3);
        usage_v = 3'd3;
        run(4);
        usage_v = 3'd0;

        // Throttle rising while locked on input 1.
        clear_src();
        add_pkt(1, 4);
        add_pkt(0, 1);
        gate = 4'b0010;
        run(1);
        usage_v = 3'd5;
        gate    = '1;
        run(5);
        usage_v = 3'd0;
        run(2);

        // FIFO backpressure holds grant and data.
        clear_src();
        for (int i = 0; i < N; i++) add_pkt(i, 2);
        drdy_v = 1'b0;
        run(3);
        drdy_v = 1'b1;
        run(3);

        // Reset while locked on input 3; input 0 wins afterwards.
        clear_src();
        add_pkt(3, 4);
        add_pkt(0, 1);
        add_pkt(1, 1);
        gate = 4'b1000;
        run(2);
        reset = 1'b0;
        gate  = '1;
        run(1);
        reset = 1'b1;
        run(4);

        // Random traffic.
        clear_src();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0) add_pkt(i, int'($urandom_range(1, 4)));
                gate[i] = ($urandom_range(0, 99) < 85);
            end
            drdy_v  = ($urandom_range(0, 3) != 0);
            usage_v = ($urandom_range(0, 3) == 0) ? USZ'($urandom_range(0, 7))
                                                  : USZ'($urandom_range(0, 3));
            reset   = ($urandom_range(0, 199) != 0);
            drive_cycle();
        end

        mon_on = 1'b0;
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
